// File: rtl/shift_reg_n.sv
// WIDTH-bit shift register with parallel load, three shift modes and a
// saturating shift counter, built from single-bit dff cells.

module dff #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) q <= INIT;
    else       q <= d;
  end

endmodule

module shift_reg_n #(
  parameter int               WIDTH       = 8,
  parameter int               N_SHIFTS    = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [WIDTH-1:0]              d,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic                          sin_l,
  input  logic                          sin_r,
  output logic [WIDTH-1:0]              q,
  output logic                          sout_msb,
  output logic                          sout_lsb,
  output logic [$clog2(N_SHIFTS+1)-1:0] count,
  output logic                          done
);

  localparam int            CW     = $clog2(N_SHIFTS + 1);
  localparam logic [CW-1:0] N_LAST = CW'(N_SHIFTS);

  logic signed [WIDTH-1:0] q_s;
  logic        [WIDTH-1:0] shl;
  logic        [WIDTH-1:0] shr;
  logic        [WIDTH-1:0] sar;
  logic        [WIDTH-1:0] shifted;
  logic        [WIDTH-1:0] q_next;
  logic        [CW-1:0]    count_next;
  logic                    shift_go;

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

  // done is a pure decode of the registered count, so it behaves as a
  // registered flag and also blocks further shifts once saturated.
  assign done     = (count == N_LAST);
  assign shift_go = en & ~load & ~done & (mode != 2'b00);

  assign q_s     = q;
  assign shl     = {q[WIDTH-2:0], sin_l};
  assign shr     = {sin_r, q[WIDTH-1:1]};
  assign sar     = q_s >>> 1;
  assign shifted = mode[0] ? (mode[1] ? sar : shl) : shr;

  assign q_next     = load ? d  : (shift_go ? shifted          : q);
  assign count_next = load ? '0 : (shift_go ? count + CW'(1'b1) : count);

  for (genvar i = 0; i < WIDTH; i++) begin : g_q
    dff #(.INIT(RESET_VALUE[i])) u_q (
      .clk   (clk),
      .reset (reset),
      .d     (q_next[i]),
      .q     (q[i])
    );
  end

  for (genvar i = 0; i < CW; i++) begin : g_cnt
    dff #(.INIT(1'b0)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .d     (count_next[i]),
      .q     (count[i])
    );
  end

endmodule

// File: doc/shift_reg_n.md
Name: shift_reg_n

Overview:
- Parametrised WIDTH-bit register with synchronous reset, parallel load, and four shift modes: hold, logical left, logical right, arithmetic right.
- It is the next generation of the single-bit D flip-flop: a WIDTH-wide storage element that the shift-add multiply / shift-subtract divide datapath uses as its accumulator and multiplier/quotient registers.
- A built-in shift counter raises `done` after a programmed number of shifts, so the sequencing FSM does not need its own counter.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- N_SHIFTS, 8, shifts accepted after a load before `done` asserts (1..WIDTH).
- RESET_VALUE, 0, value of `q` after reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous reset, active-high.
- load  input  1  parallel load request.
- d  input  WIDTH  parallel load data.
- en  input  1  shift enable; mode is acted on only when en=1.
- mode  input  2  00 hold, 01 shift left, 10 logical shift right, 11 arithmetic shift right.
- sin_l  input  1  serial in, enters at bit 0 on shift left.
- sin_r  input  1  serial in, enters at bit WIDTH-1 on logical shift right.
- q  output  WIDTH  register contents.
- sout_msb  output  1  q[WIDTH-1], bit shifted out by shift left.
- sout_lsb  output  1  q[0], bit shifted out by either right shift.
- count  output  $clog2(N_SHIFTS+1)  shifts performed since last load/reset.
- done  output  1  count == N_SHIFTS.

Behaviour:
- Interface: one clock, `clk`. Reset is `reset`, synchronous and active-high. No asynchronous paths.
- Reset values: q=RESET_VALUE, count=0, done=0. Reset is sampled only at the rising edge of clk.
- Per-edge priority: reset > load > shift > hold.
- Load (load=1, reset=0): q<=d, count<=0, done<=0. en/mode are ignored that cycle.
- Shift: occurs when en=1, load=0, reset=0, mode≠00 and done=0.
  - 01: q<={q[WIDTH-2:0], sin_l}
  - 10: q<={sin_r, q[WIDTH-1:1]}
  - 11: q<={q[WIDTH-1], q[WIDTH-1:1]} (sign replicated; sin_r ignored)
  - count<=count+1 on each shift.
- Hold cases, q and count unchanged:
  - en=0;
  - mode=00 (not counted as a shift);
  - done=1 — further shift requests are dropped, so the register saturates at exactly N_SHIFTS shifts.
- done is registered-equivalent: it goes high in the cycle after the edge where count reaches N_SHIFTS. It stays high until load or reset.
- Latency: q, count and done all reflect an edge's operation immediately after that edge (1-cycle, no pipelining).
- sout_msb/sout_lsb are combinational taps of the current q, so the bit about to be shifted out is visible before the edge.
- Reset during shifting (count mid-range) returns to reset values on that edge; in-flight shift is discarded.
- Simultaneous load and en=1 with a shift mode: load wins, count=0.
- N_SHIFTS=WIDTH: after a full logical-shift sequence every original bit has left the register.
- Implementation is built from the existing dff cell (one per bit, plus counter bits) with gate-level next-state muxing. No behavioural always-block storage.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, reset=1 for one edge, load/en random -> q=8'hA5, count=0, done=0.
- Load then shift left: load d=8'h81, then 3 edges en=1 mode=01 sin_l=1 -> q=8'h0F. sout_msb values before each edge are 1,0,0. count=3.
- Arithmetic vs logical right: load 8'h90, one edge mode=11 -> q=8'hC8. Reload 8'h90, one edge mode=10 with sin_r=0 -> q=8'h48.
- Done/saturation: N_SHIFTS=8, load 8'h01, 10 edges mode=01 sin_l=0 -> q=8'h00 after edge 8 and unchanged on edges 9-10. done=1 from edge 8. count=8.
- Priority: load=1, en=1, mode=01, d=8'h3C in the same cycle -> q=8'h3C, count=0. Next, en=0 with mode=01 for 2 edges -> q stays 8'h3C, count=0.
- Reset mid-operation: load 8'hFF, 4 shifts (count=4), then reset=1 alongside en=1 -> q=RESET_VALUE, count=0, done=0 on that edge.
